mem_stage: RTL

Memory-access pipeline stage of the five-stage MIPS core, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It passes ALU and HI/LO results through unchanged. For loads and stores it runs a request/acknowledge transaction on the data bus, and for loads it aligns and extends the returned data. While a transaction is outstanding it raises `stallreq` so the controller freezes stages 0–4 and MEM/WB inserts bubbles.

---
 rtl/mem_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: passes ALU and HI/LO results through.
// Runs request/acknowledge data-bus transactions for loads and stores.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  memop_q, memop_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] ldata_q, ldata_d;

    logic        is_load, is_store, is_half, is_word, misalign, issue;
    logic        held_load;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, ldata_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic        unused_ok;

    assign unused_ok = ^{stall[5], stall[3:0]};

    // Decode of the incoming operation
    always_comb begin
        is_load   = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
        is_store  = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
        is_half   = (ex_memop == OP_LH) || (ex_memop == OP_LHU) || (ex_memop == OP_SH);
        is_word   = (ex_memop == OP_LW) || (ex_memop == OP_SW);
        misalign  = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
        issue     = (is_load || is_store) && !misalign && !flush;
        held_load = (memop_q >= OP_LB) && (memop_q <= OP_LW);
    end

    // Big-endian lane select and store-data replication
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = ex_reg2;
        if (is_half) begin
            sel_c   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{ex_reg2[15:0]}};
        end else if (!is_word) begin
            sel_c   = 4'b1000 >> ex_mem_addr[1:0];
            wdata_c = {4{ex_reg2[7:0]}};
        end
    end

    // Load alignment and extension using the op latched at issue
    always_comb begin
        case (off_q)
            2'd0:    byte_c = dbus_rdata[31:24];
            2'd1:    byte_c = dbus_rdata[23:16];
            2'd2:    byte_c = dbus_rdata[15:8];
            default: byte_c = dbus_rdata[7:0];
        endcase
        half_c = off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
        case (memop_q)
            OP_LB:   ldata_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  ldata_c = {24'd0, byte_c};
            OP_LH:   ldata_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  ldata_c = {16'd0, half_c};
            default: ldata_c = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        memop_d = memop_q;
        off_d   = off_q;
        ldata_d = ldata_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ex_mem_addr[31:2], 2'b00};
                    sel_d   = sel_c;
                    wdata_d = wdata_c;
                    memop_d = ex_memop;
                    off_d   = ex_mem_addr[1:0];
                end
            end
            S_REQ: begin
                if (dbus_ack) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        ldata_d = ldata_c;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (!stall[4] || flush) state_d = S_IDLE;
            end
            default: begin
                // Flushed transaction still owes the bus its ack
                if (dbus_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            memop_q <= '0;
            off_q   <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            memop_q <= memop_d;
            off_q   <= off_d;
            ldata_q <= ldata_d;
        end
    end

    // Pass-through results with bubble forcing while stalled
    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_whilo = ex_whilo;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        stallreq  = 1'b0;
        exc_adel  = 1'b0;
        exc_ades  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (misalign) begin
                    exc_adel = is_load;
                    exc_ades = is_store;
                    mem_wreg = 1'b0;
                end else if (issue) begin
                    stallreq = 1'b1;
                end
            end
            S_DONE: begin
                if (held_load) mem_wdata = ldata_q;
            end
            default: stallreq = 1'b1;
        endcase
        if (stallreq) begin
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
        end
        if (rst) begin
            mem_wd    = '0;
            mem_wreg  = 1'b0;
            mem_wdata = '0;
            mem_whilo = 1'b0;
            mem_hi    = '0;
            mem_lo    = '0;
            stallreq  = 1'b0;
            exc_adel  = 1'b0;
            exc_ades  = 1'b0;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;

endmodule
